// File: rtl/mbpp_pkg.sv
// Shared types and width derivations for the modified-Booth partial-product accumulator.
package mbpp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESOLVE,
    DONE
  } state_t;

  localparam int unsigned MBPP_CSA_MAX_W = 64;

  typedef struct packed {
    logic [MBPP_CSA_MAX_W-1:0] sum;
    logic [MBPP_CSA_MAX_W-1:0] carry;
  } csa_t;

  function automatic int unsigned f_c_dw(input int unsigned m_dw, input int unsigned n_dw);
    return m_dw + n_dw;
  endfunction

  function automatic int unsigned f_pp(input int unsigned n_dw);
    return (n_dw % 2 == 1) ? (n_dw / 2 + 2) : (n_dw / 2 + 1);
  endfunction

  function automatic int unsigned f_ncyc(input int unsigned pp, input int unsigned ppc);
    return (pp + ppc - 1) / ppc;
  endfunction

endpackage

// File: rtl/mbpp_csa32.sv
// Width-parameterised 3:2 carry-save compressor; carry output is pre-shifted and truncated to W bits.
module mbpp_csa32 #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  logic [W-1:0] w_maj;

  assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = w_maj << 1;

endmodule

// File: rtl/mbpp_accum.sv
// Sequential partial-product accumulator: sums PP_PER_CYC Booth rows per cycle into a C_DW-bit product.
// Define MBPP_ACCUM_CSA_EN to keep the accumulator in carry-save form with a final RESOLVE add.
module mbpp_accum
  import mbpp_pkg::*;
#(
  parameter int unsigned M_DW       = 8,
  parameter int unsigned N_DW       = 8,
  parameter int unsigned PP_PER_CYC = 2,
  localparam int unsigned C_DW      = f_c_dw(M_DW, N_DW),
  localparam int unsigned PP        = f_pp(N_DW),
  localparam int unsigned NCYC      = f_ncyc(PP, PP_PER_CYC)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PP-1:0][C_DW-1:0]  pp_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [C_DW-1:0]          prod_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam int unsigned CW = $clog2(NCYC + 2);

  state_t                  r_state;
  state_t                  w_next;
  logic [PP-1:0][C_DW-1:0] r_rows;
  logic [C_DW-1:0]         r_sel [PP_PER_CYC];
  logic [C_DW-1:0]         w_sel [PP_PER_CYC];
  logic [CW-1:0]           r_idx;
  logic [C_DW-1:0]         r_acc;
  logic                    w_accept;
  logic                    w_last;

`ifdef MBPP_ACCUM_CSA_EN
  csa_t                    r_cs;
  logic [C_DW-1:0]         w_s [PP_PER_CYC+1];
  logic [C_DW-1:0]         w_c [PP_PER_CYC+1];

  assign w_s[0] = r_cs.sum[C_DW-1:0];
  assign w_c[0] = r_cs.carry[C_DW-1:0];

  for (genvar k = 0; k < PP_PER_CYC; k++) begin : g_csa
    mbpp_csa32 #(.W(C_DW)) u_csa (
      .i_a     (w_s[k]),
      .i_b     (w_c[k]),
      .i_c     (r_sel[k]),
      .o_sum   (w_s[k+1]),
      .o_carry (w_c[k+1])
    );
  end
`else
  logic [C_DW-1:0]         w_grp;

  always_comb begin
    w_grp = '0;
    for (int unsigned k = 0; k < PP_PER_CYC; k++) begin
      w_grp = w_grp + r_sel[k];
    end
  end
`endif

  assign prod_o = r_acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    w_accept = 1'b0;
    w_last   = (r_idx == CW'(NCYC));
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_accept = 1'b1;
          w_next   = ACC;
        end
      end
      ACC: begin
        if (w_last) begin
`ifdef MBPP_ACCUM_CSA_EN
          w_next = RESOLVE;
`else
          w_next = DONE;
`endif
        end
      end
      RESOLVE: w_next = DONE;
      DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
        if (ready_i) begin
          if (valid_i) begin
            w_accept = 1'b1;
            w_next   = ACC;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Row groups are registered one cycle ahead of the accumulator, so ACC spans NCYC+1 edges:
  // the first loads group 0, the last folds in group NCYC-1.
  always_comb begin
    for (int unsigned k = 0; k < PP_PER_CYC; k++) begin
      w_sel[k] = '0;
    end
    for (int unsigned g = 0; g < NCYC; g++) begin
      if (r_idx == CW'(g)) begin
        for (int unsigned k = 0; k < PP_PER_CYC; k++) begin
          if (g * PP_PER_CYC + k < PP) begin
            w_sel[k] = r_rows[g * PP_PER_CYC + k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rows <= '0;
      r_idx  <= '0;
      r_acc  <= '0;
      for (int unsigned k = 0; k < PP_PER_CYC; k++) begin
        r_sel[k] <= '0;
      end
`ifdef MBPP_ACCUM_CSA_EN
      r_cs   <= '0;
`endif
    end else if (w_accept) begin
      r_rows <= pp_i;
      r_idx  <= '0;
      r_acc  <= '0;
      for (int unsigned k = 0; k < PP_PER_CYC; k++) begin
        r_sel[k] <= '0;
      end
`ifdef MBPP_ACCUM_CSA_EN
      r_cs   <= '0;
`endif
    end else if (r_state == ACC) begin
      r_idx <= r_idx + 1'b1;
      for (int unsigned k = 0; k < PP_PER_CYC; k++) begin
        r_sel[k] <= w_sel[k];
      end
`ifdef MBPP_ACCUM_CSA_EN
      r_cs  <= '{sum: MBPP_CSA_MAX_W'(w_s[PP_PER_CYC]), carry: MBPP_CSA_MAX_W'(w_c[PP_PER_CYC])};
`else
      r_acc <= r_acc + w_grp;
`endif
    end
`ifdef MBPP_ACCUM_CSA_EN
    else if (r_state == RESOLVE) begin
      r_acc <= r_cs.sum[C_DW-1:0] + r_cs.carry[C_DW-1:0];
    end
`endif
  end

endmodule

// File: tb/tb_mbpp_accum.sv
// Self-checking bench for mbpp_accum: directed corners, backpressure, async reset, and random products.
module tb_mbpp_accum;

  localparam int NC [4] = '{3, 5, 1, 3};
`ifdef MBPP_ACCUM_CSA_EN
  localparam int XL = 2;
`else
  localparam int XL = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0][15:0] pp8;
  logic [4:0][14:0] pp7;
  logic             vi [4];
  logic             ri [4];
  logic             ro [4];
  logic             vo [4];
  logic [15:0]      prod8 [3];
  logic [14:0]      prod7;
  int               total = 0;
  int               bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  mbpp_accum #(.M_DW(8), .N_DW(8), .PP_PER_CYC(2)) u_p2 (
    .clk_i(clk), .rst_i(rst), .pp_i(pp8), .valid_i(vi[0]), .ready_o(ro[0]),
    .prod_o(prod8[0]), .valid_o(vo[0]), .ready_i(ri[0]));
  mbpp_accum #(.M_DW(8), .N_DW(8), .PP_PER_CYC(1)) u_p1 (
    .clk_i(clk), .rst_i(rst), .pp_i(pp8), .valid_i(vi[1]), .ready_o(ro[1]),
    .prod_o(prod8[1]), .valid_o(vo[1]), .ready_i(ri[1]));
  mbpp_accum #(.M_DW(8), .N_DW(8), .PP_PER_CYC(5)) u_p5 (
    .clk_i(clk), .rst_i(rst), .pp_i(pp8), .valid_i(vi[2]), .ready_o(ro[2]),
    .prod_o(prod8[2]), .valid_o(vo[2]), .ready_i(ri[2]));
  mbpp_accum #(.M_DW(8), .N_DW(7), .PP_PER_CYC(2)) u_n7 (
    .clk_i(clk), .rst_i(rst), .pp_i(pp7), .valid_i(vi[3]), .ready_o(ro[3]),
    .prod_o(prod7), .valid_o(vo[3]), .ready_i(ri[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Radix-4 Booth rows of m*n (n signed, at most 8 bits) plus a random split between rows 0 and 4.
  function automatic logic [4:0][15:0] f_rows(input int m, input int n, input int r);
    logic [4:0][15:0] rows;
    int nn;
    int d;
    int bl;
    nn = n;
    rows = '0;
    for (int j = 0; j < 4; j++) begin
      bl = 0;
      if (j > 0) bl = int'(nn[2*j-1]);
      d = -2 * int'(nn[2*j+1]) + int'(nn[2*j]) + bl;
      rows[j] = 16'(d * m * (1 << (2 * j)));
    end
    rows[0] = rows[0] + 16'(r);
    rows[4] = 16'(-r);
    return rows;
  endfunction

  function automatic logic [15:0] prod_of(input int d);
    if (d == 3) return {1'b0, prod7};
    return prod8[d];
  endfunction

  task automatic scramble();
    pp8 = {$urandom(), $urandom(), $urandom()};
    pp7 = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic xact(input int m, input int n, input int m7, input int n7, input bit use7,
                      output logic [15:0] got0);
    logic [4:0][15:0] r7;
    logic [15:0]      exp_p [4];
    logic [15:0]      got [4];
    bit               act [4];
    bit               seen [4];
    int               lat [4];
    pp8 = f_rows(m, n, int'($urandom()));
    r7  = f_rows(m7, n7, int'($urandom()));
    for (int i = 0; i < 5; i++) pp7[i] = r7[i][14:0];
    for (int d = 0; d < 3; d++) exp_p[d] = 16'(m * n);
    exp_p[3] = {1'b0, 15'(m7 * n7)};
    for (int d = 0; d < 4; d++) begin
      act[d]  = (d < 3) || use7;
      seen[d] = 1'b0;
      lat[d]  = 0;
      got[d]  = '0;
      if (act[d]) chk($sformatf("ready_idle%0d", d), ro[d], 1'b1);
      vi[d] = act[d];
    end
    tick();
    for (int d = 0; d < 4; d++) vi[d] = 1'b0;
    scramble();
    for (int c = 1; c <= 10; c++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        if (act[d] && !seen[d] && vo[d] === 1'b1) begin
          seen[d] = 1'b1;
          lat[d]  = c;
          got[d]  = prod_of(d);
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      if (act[d]) begin
        chk($sformatf("latency%0d", d), lat[d], NC[d] + XL);
        chk($sformatf("product%0d m=%0d n=%0d", d, (d == 3) ? m7 : m, (d == 3) ? n7 : n),
            got[d], exp_p[d]);
      end
    end
    for (int d = 0; d < 4; d++) ri[d] = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) ri[d] = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (act[d]) chk($sformatf("valid_after_hs%0d", d), vo[d], 1'b0);
    end
    got0 = got[0];
  endtask

  task automatic wait_p2(output int lat);
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      tick();
      if (vo[0] === 1'b1) lat = c;
    end
  endtask

  initial begin
    logic [15:0] g;
    logic [15:0] e1;
    logic [15:0] e2;
    int          lat;
    bit          anyv;
    for (int d = 0; d < 4; d++) begin
      vi[d] = 1'b0;
      ri[d] = 1'b0;
    end
    pp8 = '0;
    pp7 = '0;

    repeat (2) tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_ready%0d", d), ro[d], 1'b1);
      chk($sformatf("rst_valid%0d", d), vo[d], 1'b0);
    end
    chk("rst_prod", prod8[0], 16'h0000);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", ro[0], 1'b1);
    chk("post_rst_valid", vo[0], 1'b0);

    xact(-1, -1, -1, int'($signed(7'($urandom()))), 1'b1, g);
    chk("corner_m1_m1", g, 16'h0001);
    xact(-128, -128, -128, -64, 1'b1, g);
    chk("corner_m128_m128", g, 16'h4000);
    xact(127, -128, 127, -64, 1'b1, g);
    chk("corner_127_m128", g, 16'hC080);
    xact(0, -77, 0, 63, 1'b1, g);
    chk("corner_0_m77", g, 16'h0000);

    e1 = 16'(93 * -41);
    pp8 = f_rows(93, -41, int'($urandom()));
    vi[0] = 1'b1;
    tick();
    vi[0] = 1'b0;
    scramble();
    wait_p2(lat);
    chk("bp_latency", lat, NC[0] + XL);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_hold", vo[0], 1'b1);
      chk("bp_prod_hold", prod8[0], e1);
      chk("bp_ready_low", ro[0], 1'b0);
    end
    e2 = 16'(-100 * 57);
    pp8 = f_rows(-100, 57, int'($urandom()));
    vi[0] = 1'b1;
    ri[0] = 1'b1;
    #1;
    chk("b2b_ready_comb", ro[0], 1'b1);
    tick();
    vi[0] = 1'b0;
    ri[0] = 1'b0;
    scramble();
    chk("b2b_valid_drop", vo[0], 1'b0);
    wait_p2(lat);
    chk("b2b_latency", lat, NC[0] + XL);
    chk("b2b_prod", prod8[0], e2);
    ri[0] = 1'b1;
    tick();
    ri[0] = 1'b0;

    pp8 = f_rows(55, 66, int'($urandom()));
    vi[0] = 1'b1;
    tick();
    vi[0] = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", vo[0], 1'b0);
    chk("midrst_ready", ro[0], 1'b1);
    chk("midrst_prod", prod8[0], 16'h0000);
    tick();
    rst = 1'b0;
    anyv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vo[0] !== 1'b0) anyv = 1'b1;
    end
    chk("midrst_no_stale", anyv, 1'b0);
    chk("midrst_ready_after", ro[0], 1'b1);

    for (int i = 0; i < 1000; i++) begin
      xact(int'($signed(8'($urandom()))), int'($signed(8'($urandom()))),
           int'($signed(8'($urandom()))), int'($signed(7'($urandom()))), i < 500, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
